// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: response-owner codes and age counter width.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

  localparam int ARB_AGE_W = 4;

endpackage

// File: rtl/unified_mem_arbiter_age_counter.sv
// Saturating starvation counter: counts consecutive cycles the fetch port is kept waiting.
module arb_age_counter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [ARB_AGE_W-1:0] age,
  output logic                 sat
);

  assign sat = (age == ARB_AGE_W'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= '0;
    end else if (clr) begin
      age <= '0;
    end else if (inc && !sat) begin
      age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port synchronous memory between fetch (IF) and load/store (D),
// and routes read data back to whichever port owned the grant.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata
);

  // Handshake: a requester holds req and its fields steady until it sees gnt in the
  // same cycle; a gnt cycle is the transfer, and each load yields exactly one rvalid.

  logic [ARB_AGE_W-1:0] age;
  logic                 age_sat;
  owner_e               own_in;
  owner_e               own_s0;
  owner_e               own_out;

  arb_age_counter #(.MAX_WAIT(MAX_WAIT)) u_age (
    .clk (clk),
    .rst (rst),
    .inc (if_req && !if_gnt),
    .clr (if_gnt || !if_req),
    .age (age),
    .sat (age_sat)
  );

  // D wins contention unless IF has been starved for MAX_WAIT cycles.
  assign d_gnt  = !rst && d_req && !(if_req && age_sat);
  assign if_gnt = !rst && if_req && !d_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'h0;
    own_in    = OWN_NONE;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
      own_in    = d_we ? OWN_NONE : OWN_D;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
      mem_be    = 4'hF;
      own_in    = OWN_IF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_s0 <= OWN_NONE;
    end else begin
      own_s0 <= own_in;
    end
  end

  // Owner pipeline depth tracks memory read latency so the tag lines up with mem_rdata.
  generate
    if (MEM_LAT == 1) begin : g_lat1
      assign own_out = own_s0;
    end else begin : g_lat2
      owner_e own_s1;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          own_s1 <= OWN_NONE;
        end else begin
          own_s1 <= own_s0;
        end
      end
      assign own_out = own_s1;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= (own_out == OWN_IF);
      d_rvalid  <= (own_out == OWN_D);
      if (own_out == OWN_IF) begin
        if_rdata <= mem_rdata;
      end
      if (own_out == OWN_D) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter with a two-cycle-latency memory model.
module tb_unified_mem_arbiter;

  localparam int ADDR_W   = 10;
  localparam int MEM_LAT  = 2;
  localparam int MAX_WAIT = 4;
  localparam logic [31:0] BASE = 32'hC0DE_0000;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;

  int n_cmp;
  int n_bad;
  logic preload;

  unified_mem_arbiter #(
    .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model: word i preloads to BASE+i, 2-cycle read ----------------
  logic [31:0] mem_model [1024];
  logic [31:0] rd_p1, rd_p2;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem_model[i] <= BASE + 32'(i);
      rd_p1 <= '0;
      rd_p2 <= '0;
    end else begin
      if (mem_en) begin
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end else begin
          rd_p1 <= mem_model[mem_addr];
        end
      end
      rd_p2 <= rd_p1;
    end
  end
  assign mem_rdata = rd_p2;

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [ADDR_W-1:0] ia,
                       input logic dr, input logic dw, input logic [ADDR_W-1:0] da,
                       input logic [31:0] dd, input logic [3:0] db);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
    d_be    = db;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    preload = 1'b1;
    drive(1'b1, 10'd0, 1'b1, 1'b0, 10'd1, '0, 4'hF);
    tick(); tick(); #1;
    n_cmp++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0) begin
      n_bad++; $display("FAIL reset_gnt got if=%b d=%b en=%b exp 0 0 0", if_gnt, d_gnt, mem_en); end
    n_cmp++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_resp got %b %b %h %h exp 0 0 0 0", if_rvalid, d_rvalid, if_rdata, d_rdata); end
    // mid-traffic: D load then IF fetch in flight, then reset hits
    tick(); rst = 1'b0; preload = 1'b0;
    drive(1'b1, 10'd2, 1'b1, 1'b0, 10'd1, '0, 4'hF); #1;
    n_cmp++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      n_bad++; $display("FAIL reset_pre_gnt got d=%b if=%b exp 1 0", d_gnt, if_gnt); end
    tick(); d_req = 1'b0;
    tick(); rst = 1'b1; #1;
    n_cmp++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'h0) begin
      n_bad++; $display("FAIL reset_mid_mem got gnt=%b%b en=%b we=%b be=%h exp 0", if_gnt, d_gnt, mem_en, mem_we, mem_be); end
    n_cmp++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_rvalid got if=%b d=%b exp 0 0", if_rvalid, d_rvalid); end
    tick(); rst = 1'b0; idle();
    for (int c = 0; c < 4; c++) begin
      tick(); #1;
      n_cmp++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
        n_bad++; $display("FAIL reset_after_%0d got if=%b d=%b exp 0 0", c, if_rvalid, d_rvalid); end
    end
  endtask

  task automatic test_if_only();
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c < 4) drive(1'b1, 10'(c), 1'b0, 1'b0, '0, '0, 4'h0);
      else idle();
      #1;
      n_cmp++; if (if_gnt !== (c < 4)) begin
        n_bad++; $display("FAIL if_only_gnt c=%0d got %b exp %b", c, if_gnt, (c < 4)); end
      if (c < 4) begin
        n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'hF || mem_addr !== 10'(c)) begin
          n_bad++; $display("FAIL if_only_mem c=%0d got en=%b we=%b be=%h a=%0d exp 1 0 f %0d", c, mem_en, mem_we, mem_be, mem_addr, c); end
      end
      n_cmp++; if (if_rvalid !== (c >= 3 && c <= 6) || d_rvalid !== 1'b0) begin
        n_bad++; $display("FAIL if_only_rvalid c=%0d got if=%b d=%b", c, if_rvalid, d_rvalid); end
      if (c >= 3 && c <= 6) begin
        n_cmp++; if (if_rdata !== BASE + 32'(c - 3)) begin
          n_bad++; $display("FAIL if_only_rdata c=%0d got %h exp %h", c, if_rdata, BASE + 32'(c - 3)); end
      end
    end
  endtask

  task automatic test_contention();
    int run;
    int max_run;
    run = 0;
    max_run = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      drive(1'b1, 10'd100, 1'b1, 1'b0, 10'd200, '0, 4'hF);
      #1;
      n_cmp++; if (if_gnt !== (c % 5 == 4) || d_gnt !== (c % 5 != 4)) begin
        n_bad++; $display("FAIL contention_gnt c=%0d got if=%b d=%b exp if=%b", c, if_gnt, d_gnt, (c % 5 == 4)); end
      if (if_gnt) run = 0;
      else run++;
      if (run > max_run) max_run = run;
    end
    n_cmp++; if (max_run > MAX_WAIT) begin
      n_bad++; $display("FAIL contention_wait got %0d exp <= %0d", max_run, MAX_WAIT); end
    tick(); idle();
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_store_load();
    tick();
    drive(1'b0, '0, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF); #1;
    n_cmp++; if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd5
                 || mem_wdata !== 32'hDEADBEEF || mem_be !== 4'hF) begin
      n_bad++; $display("FAIL store_mem got g=%b en=%b we=%b a=%0d d=%h be=%h", d_gnt, mem_en, mem_we, mem_addr, mem_wdata, mem_be); end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, 10'd5, '0, 4'hF); #1;
    n_cmp++; if (d_gnt !== 1'b1 || mem_we !== 1'b0) begin
      n_bad++; $display("FAIL load_gnt got g=%b we=%b exp 1 0", d_gnt, mem_we); end
    for (int c = 2; c < 7; c++) begin
      tick(); idle(); #1;
      n_cmp++; if (d_rvalid !== (c == 4) || if_rvalid !== 1'b0) begin
        n_bad++; $display("FAIL store_load_rvalid c=%0d got d=%b if=%b exp d=%b", c, d_rvalid, if_rvalid, (c == 4)); end
      if (c == 4 || c == 5) begin
        n_cmp++; if (d_rdata !== 32'hDEADBEEF) begin
          n_bad++; $display("FAIL store_load_rdata c=%0d got %h exp deadbeef", c, d_rdata); end
      end
    end
  endtask

  task automatic test_byte_store();
    tick(); drive(1'b0, '0, 1'b1, 1'b1, 10'd9, 32'h11223344, 4'hF);
    tick(); drive(1'b0, '0, 1'b1, 1'b1, 10'd9, 32'h0000AB00, 4'b0010);
    tick(); drive(1'b0, '0, 1'b1, 1'b0, 10'd9, '0, 4'hF);
    for (int c = 3; c < 7; c++) begin
      tick(); idle(); #1;
      n_cmp++; if (d_rvalid !== (c == 5)) begin
        n_bad++; $display("FAIL byte_rvalid c=%0d got %b exp %b", c, d_rvalid, (c == 5)); end
      if (c == 5) begin
        n_cmp++; if (d_rdata !== 32'h1122AB44) begin
          n_bad++; $display("FAIL byte_rdata got %h exp 1122ab44", d_rdata); end
      end
    end
  endtask

  task automatic test_same_addr();
    tick();
    drive(1'b1, 10'd12, 1'b1, 1'b1, 10'd12, 32'hCAFEF00D, 4'hF); #1;
    n_cmp++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      n_bad++; $display("FAIL same_addr_gnt0 got d=%b if=%b exp 1 0", d_gnt, if_gnt); end
    tick(); d_req = 1'b0; #1;
    n_cmp++; if (if_gnt !== 1'b1 || mem_addr !== 10'd12) begin
      n_bad++; $display("FAIL same_addr_gnt1 got if=%b a=%0d exp 1 12", if_gnt, mem_addr); end
    for (int c = 2; c < 6; c++) begin
      tick(); idle(); #1;
      n_cmp++; if (if_rvalid !== (c == 4)) begin
        n_bad++; $display("FAIL same_addr_rvalid c=%0d got %b exp %b", c, if_rvalid, (c == 4)); end
      if (c == 4) begin
        n_cmp++; if (if_rdata !== 32'hCAFEF00D) begin
          n_bad++; $display("FAIL same_addr_rdata got %h exp cafef00d", if_rdata); end
      end
    end
  endtask

  task automatic test_interleave();
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] e;
    int n_if;
    int n_d;
    n_if = 0;
    n_d = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c < 8 && c % 2 == 0) drive(1'b1, 10'(20 + c / 2), 1'b0, 1'b0, '0, '0, 4'h0);
      else if (c < 8) drive(1'b0, '0, 1'b1, 1'b0, 10'(40 + c / 2), '0, 4'hF);
      else idle();
      #1;
      if (c < 8) begin
        n_cmp++; if (if_gnt !== (c % 2 == 0) || d_gnt !== (c % 2 == 1)) begin
          n_bad++; $display("FAIL interleave_gnt c=%0d got if=%b d=%b", c, if_gnt, d_gnt); end
        if (c % 2 == 0) exp_if_q.push_back(BASE + 32'(20 + c / 2));
        else exp_d_q.push_back(BASE + 32'(40 + c / 2));
      end
      if (if_rvalid) begin
        n_if++;
        e = (exp_if_q.size() > 0) ? exp_if_q.pop_front() : 32'hXXXX_XXXX;
        n_cmp++; if (if_rdata !== e) begin
          n_bad++; $display("FAIL interleave_if c=%0d got %h exp %h", c, if_rdata, e); end
      end
      if (d_rvalid) begin
        n_d++;
        e = (exp_d_q.size() > 0) ? exp_d_q.pop_front() : 32'hXXXX_XXXX;
        n_cmp++; if (d_rdata !== e) begin
          n_bad++; $display("FAIL interleave_d c=%0d got %h exp %h", c, d_rdata, e); end
      end
    end
    n_cmp++; if (n_if != 4 || n_d != 4 || exp_if_q.size() != 0 || exp_d_q.size() != 0) begin
      n_bad++; $display("FAIL interleave_count got if=%0d d=%0d exp 4 4", n_if, n_d); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    test_reset();
    test_if_only();
    test_contention();
    test_store_load();
    test_byte_store();
    test_same_addr();
    test_interleave();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
